// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and single-cycle access sequencer for the data memory
module dmem_arbiter #(
  parameter int DEPTH = 206
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state;
  logic        sel, last_grant, we_q, oob;
  logic        e0, e1, grant, win;
  logic [31:0] win_addr;
  // eligibility excludes the port being acked in DONE; ties go to the port not granted last
  always_comb begin
    e0 = req0 & ~(state == DONE & ~sel);
    e1 = req1 & ~(state == DONE & sel);
    grant = (state != ACCESS) & (e0 | e1);
    win = (e0 & e1) ? ~last_grant : e1;
    win_addr = win ? addr1 : addr0;
  end
  assign busy = state != IDLE;
  assign mem_we = (state == ACCESS) & we_q & ~oob & ~reset;
  // sequencer: grant latches the winner's request, ACCESS captures read data, DONE acks
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      rdata <= '0;
      mem_addr <= '0;
      mem_din <= '0;
      we_q <= 1'b0;
      oob <= 1'b0;
      last_grant <= 1'b1;
      sel <= 1'b0;
    end else begin
      ack0 <= (state == ACCESS) & ~sel;
      ack1 <= (state == ACCESS) & sel;
      err0 <= (state == ACCESS) & ~sel & oob;
      err1 <= (state == ACCESS) & sel & oob;
      if (state == ACCESS) begin
        if (!we_q) rdata <= oob ? '0 : mem_dout;
        state <= DONE;
      end else if (grant) begin
        state <= ACCESS;
        sel <= win;
        last_grant <= win;
        mem_addr <= win_addr;
        mem_din <= win ? wdata1 : wdata0;
        we_q <= win ? we1 : we0;
        oob <= win_addr >= 32'(DEPTH);
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural falling-edge-read memory
module tb_dmem_arbiter;
  logic        clk = 0, reset = 1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic [31:0] mem_dout;
  logic        ack0, ack1, err0, err1, busy, mem_we;
  logic [31:0] rdata, mem_addr, mem_din;
  logic [31:0] mem [0:255];
  int          passed = 0, total = 0, cyc = 0, last_ack = 0;
  typedef struct {int port; logic err; logic rd; logic [31:0] data; int gap;} exp_t;
  exp_t        sb[$];
  exp_t        e_m;

  dmem_arbiter #(.DEPTH(206)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory: writes on the rising edge, reads on the falling edge
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | 32'(i);
    mem[5] = 32'h0000_1234;
    mem[3] = 32'h0000_00AA;
    mem[17] = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_we && mem_addr < 256) mem[mem_addr[7:0]] = mem_din;
    end
  end

  always @(negedge clk) mem_dout <= (mem_addr < 206) ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: every ack is matched against the oldest expected response
  always @(negedge clk) begin
    if (ack0 | ack1) begin
      chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none (cycle %0d)", ack0, ack1, cyc);
      end else begin
        e_m = sb.pop_front();
        chk("ack_port", 32'(ack1), 32'(e_m.port));
        chk("err", 32'(e_m.port != 0 ? err1 : err0), 32'(e_m.err));
        chk("err_other", 32'(e_m.port != 0 ? err0 : err1), 32'd0);
        if (e_m.rd) chk("rdata", rdata, e_m.data);
        if (e_m.gap != 0) chk("ack_gap", 32'(cyc - last_ack), 32'(e_m.gap));
      end
      last_ack = cyc;
    end
  end

  task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_data, input int exp_we_n);
    int n = 0, wec = 0;
    logic got = 0;
    sb.push_back('{p, exp_err, ~w, exp_data, 0});
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      wec += int'(mem_we);
      got = (p != 0) ? ack1 : ack0;
    end
    if (!got) begin
      total++;
      $display("FAIL ack_timeout: got no ack from port %0d expected one within 20 cycles", p);
    end
    @(posedge clk); #1;
    req0 = 0;
    req1 = 0;
    chk("we_cycles", 32'(wec), 32'(exp_we_n));
  endtask

  initial begin
    int n0, n1, k;
    logic a0, a1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_err0", 32'(err0), 0);
    chk("rst_err1", 32'(err1), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    reset = 0;
    // single reads and writes
    access(0, 0, 32'd5, 32'd0, 0, 32'h0000_1234, 0);
    access(1, 1, 32'd17, 32'hDEAD_BEEF, 0, 32'd0, 1);
    access(1, 0, 32'd17, 32'd0, 0, 32'hDEAD_BEEF, 0);
    // contention: three reads per port, strictly alternating from port 0
    sb.push_back('{0, 1'b0, 1'b1, 32'hC000_000A, 0});
    sb.push_back('{1, 1'b0, 1'b1, 32'hC000_000B, 2});
    sb.push_back('{0, 1'b0, 1'b1, 32'hC000_000C, 2});
    sb.push_back('{1, 1'b0, 1'b1, 32'hC000_000D, 2});
    sb.push_back('{0, 1'b0, 1'b1, 32'hC000_000E, 2});
    sb.push_back('{1, 1'b0, 1'b1, 32'hC000_000F, 2});
    we0 = 0; we1 = 0; addr0 = 10; addr1 = 11; req0 = 1; req1 = 1;
    n0 = 0; n1 = 0; k = 0;
    while ((n0 < 3 || n1 < 3) && k < 40) begin
      @(negedge clk);
      a0 = ack0;
      a1 = ack1;
      @(posedge clk); #1;
      k++;
      if (a0) begin n0++; addr0 = 32'(10 + 2 * n0); if (n0 == 3) req0 = 0; end
      if (a1) begin n1++; addr1 = 32'(11 + 2 * n1); if (n1 == 3) req1 = 0; end
    end
    if (k >= 40) begin
      total++;
      $display("FAIL contention_timeout: got %0d/%0d acks expected 3/3", n0, n1);
    end
    req0 = 0; req1 = 0;
    repeat (2) @(posedge clk); #1;
    // out-of-range write and read
    access(0, 1, 32'd206, 32'h77, 1, 32'd0, 0);
    access(0, 0, 32'hFFFF_FFFF, 32'd0, 1, 32'd0, 0);
    // reset asserted during a write's ACCESS cycle
    req1 = 1; we1 = 1; addr1 = 3; wdata1 = 32'h55;
    @(posedge clk); #1;
    chk("busy_access", 32'(busy), 1);
    reset = 1;
    req1 = 0;
    @(negedge clk);
    chk("rst_access_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_hold_we", 32'(mem_we), 0);
    chk("rst_hold_ack1", 32'(ack1), 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_ack1", 32'(ack1), 0);
    @(posedge clk); #1;
    access(1, 0, 32'd3, 32'd0, 0, 32'h0000_00AA, 0);
    // back-to-back reads from port 0 with the address advanced after each ack
    sb.push_back('{0, 1'b0, 1'b1, 32'hC000_0000, 0});
    sb.push_back('{0, 1'b0, 1'b1, 32'hC000_0001, 0});
    sb.push_back('{0, 1'b0, 1'b1, 32'hC000_0002, 0});
    sb.push_back('{0, 1'b0, 1'b1, 32'h0000_00AA, 0});
    we0 = 0; addr0 = 0; req0 = 1;
    n0 = 0; k = 0;
    while (n0 < 4 && k < 40) begin
      @(negedge clk);
      a0 = ack0;
      @(posedge clk); #1;
      k++;
      if (a0) begin n0++; addr0 = 32'(n0); if (n0 == 4) req0 = 0; end
    end
    if (k >= 40) begin
      total++;
      $display("FAIL b2b_timeout: got %0d acks expected 4", n0);
    end
    req0 = 0;
    repeat (4) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
